i2c_cmd_sequencer: RTL and testbench
====================================

// Module: i2c_cmd_sequencer
// PURPOSE
//  Upstream feeder for i2c_controller. Buffers I2C byte commands {rw, addr, wdata} in a FIFO.
//  Issues each command to the controller through its addr/data_in/rw/enable/ready interface.
//  Waits for completion and returns exactly one response per command: read data, or zero for writes.
//  Lets a host or test sequencer queue back-to-back transactions without polling the controller's ready.
// PARAMETERS
//  DEPTH          4    command FIFO entries; power of 2, >= 2
//  TIMEOUT_CYCLES 1024 cycles allowed per transaction before abort (used only with I2C_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in  1   system clock; all logic on rising edge
//  rst          in  1   synchronous, active-high reset
//  cmd_valid    in  1   command offered
//  cmd_ready    out 1   FIFO can accept; equals !full
//  cmd_rw       in  1   1 = read, 0 = write
//  cmd_addr     in  7   7-bit slave address
//  cmd_wdata    in  8   write byte; ignored for reads
//  rsp_valid    out 1   response available
//  rsp_ready    in  1   response consumed
//  rsp_data     out 8   read byte; 8'h00 for writes
//  rsp_err      out 1   transaction aborted by timeout; constant 0 without I2C_SEQ_TIMEOUT_EN
//  busy         out 1   FSM not IDLE, or FIFO not empty
//  level        out $clog2(DEPTH)+1   FIFO occupancy
//  ctl_addr     out 7   to controller addr
//  ctl_data_in  out 8   to controller data_in
//  ctl_rw       out 1   to controller rw
//  ctl_enable   out 1   to controller enable
//  ctl_data_out in  8   from controller data_out
//  ctl_ready    in  1   from controller ready; high = idle
// BEHAVIOUR
//  Reset: FIFO flushed (level=0); FSM=IDLE.
//   Outputs 0: cmd_ready, rsp_valid, rsp_data, rsp_err, busy, ctl_addr, ctl_data_in, ctl_rw, ctl_enable.
//   cmd_ready goes high the first cycle after rst deasserts.
//  Reset mid-transaction: ctl_enable drops at that edge; queued commands and the pending response are discarded.
//  Push: on cmd_valid && cmd_ready. No fall-through: an entry pushed at edge N is poppable from edge N+1.
//  Full: cmd_ready=0 and the push is not taken, even if a pop occurs in the same cycle.
//  Pointers wrap modulo DEPTH. level is updated correctly on simultaneous push and pop.
//  FSM states (encoded in the package):
//   IDLE:  if !empty && ctl_ready, pop the head entry and register it into ctl_addr/ctl_data_in/ctl_rw.
//          Set ctl_enable=1 and go to ISSUE. First ctl_enable assertion is 2 edges after the cmd handshake.
//   ISSUE: hold ctl_enable=1 and the ctl_* fields until ctl_ready==0.
//          Then set ctl_enable=0 and go to WAIT. This hold is the controller's start acknowledge.
//   WAIT:  on ctl_ready==1, capture rsp_data = rw ? ctl_data_out : 8'h00, set rsp_err=0 and rsp_valid=1.
//          Then go to RESP.
//   RESP:  hold rsp_* until rsp_ready. On that edge set rsp_valid=0 and go to IDLE.
//  ctl_* fields change only in IDLE, so they are stable for the whole transaction.
//  One outstanding transaction at a time.
//  The next pop happens no earlier than the cycle after the response handshake.
//  rsp_valid may stay high indefinitely. The FIFO keeps accepting commands meanwhile.
// CONFIGURATION
//  I2C_SEQ_TIMEOUT_EN defined:
//   A cycle counter clears on entering ISSUE and counts in ISSUE and WAIT.
//   When it reaches TIMEOUT_CYCLES-1: ctl_enable=0, rsp_data=0, rsp_err=1, rsp_valid=1, go to RESP.
//   The counter is held at 0 in IDLE and RESP.
//  I2C_SEQ_TIMEOUT_EN undefined:
//   No counter. ISSUE and WAIT wait forever. rsp_err is tied to 0.
// STRUCTURE
//  Package i2c_seq_pkg holds:
//   - FSM state typedef: IDLE, ISSUE, WAIT, RESP.
//   - Command field widths and CMD_W=16, with field offsets RW=15, ADDR=14:8, WDATA=7:0.
//  Sub-module i2c_seq_fifo: synchronous FIFO, parameter DEPTH, width CMD_W.
//   Ports: push, pop, din, dout, full, empty, level.
//  The top level holds the FSM, the ctl/rsp registers and the optional timeout counter.
// TESTING
//  Bench uses an i2c_controller behavioural model plus i2c_slave_controller; clk period 2 ns.
//  Reset scenario: rst=1 for 50 cycles.
//   -> All outputs 0. Once released, cmd_ready=1 and level=0.
//  Single write: push {0, 7'h2A, 8'hAA}.
//   -> ctl_enable rises 2 edges after the push, ctl_addr=7'h2A, ctl_data_in=8'hAA, ctl_rw=0.
//   -> Exactly one response: rsp_data=00, rsp_err=0.
//  Read: push {1, 7'h2A, xx} with the slave returning 8'h55.
//   -> rsp_data=8'h55, rsp_err=0. ctl_rw=1 for the whole transaction.
//  Backpressure: push DEPTH+1 commands with rsp_ready=0.
//   -> The last push stalls (cmd_ready=0) at level=DEPTH.
//   -> Releasing rsp_ready drains all commands in order, with one response each.
//  Reset mid-read: assert rst while in WAIT.
//   -> ctl_enable=0 and rsp_valid=0 after the edge. level=0. No stale response afterwards.
//  Timeout (I2C_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): model holds ctl_ready=0.
//   -> rsp_valid with rsp_err=1 and rsp_data=0 arrives 16 cycles after ISSUE is entered.
//   -> The next queued command then proceeds.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types and command field layout for the I2C command sequencer.
// Command word: {rw, addr[6:0], wdata[7:0]}.
package i2c_seq_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int CMD_W  = 1 + ADDR_W + DATA_W;

    localparam int CMD_RW       = 15;
    localparam int CMD_ADDR_HI  = 14;
    localparam int CMD_ADDR_LO  = 8;
    localparam int CMD_WDATA_HI = 7;
    localparam int CMD_WDATA_LO = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/i2c_seq_fifo.sv
// Synchronous command FIFO, registered storage, no fall-through.
// Latency: an entry written at edge N is visible on dout from edge N+1.
// Backpressure: push ignored while full, pop ignored while empty.
module i2c_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly PTR_W bits wide, so DEPTH being a power of 2 gives free wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C byte commands and runs them one at a time on i2c_controller, one response each.
// Latency: ctl_enable rises on the edge after the push edge; response registers one edge after ctl_ready returns.
// Backpressure: cmd_ready = !full; response held until rsp_ready. Optional abort timeout: I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic [ADDR_W-1:0]      ctl_addr,
    output logic [DATA_W-1:0]      ctl_data_in,
    output logic                   ctl_rw,
    output logic                   ctl_enable,
    input  logic [DATA_W-1:0]      ctl_data_out,
    input  logic                   ctl_ready
);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic              push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CMD_W-1:0]  fifo_din;
    logic [CMD_W-1:0]  fifo_dout;
    logic              timeout_hit;

    logic [ADDR_W-1:0] ctl_addr_nxt;
    logic [DATA_W-1:0] ctl_data_in_nxt;
    logic              ctl_rw_nxt;
    logic              ctl_enable_nxt;
    logic              rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_data_nxt;

    // Held low during reset so the host never sees a ready FIFO mid-flush.
    assign cmd_ready = !rst && !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || !fifo_empty;

    always_comb begin
        fifo_din = '0;
        fifo_din[CMD_RW]                       = cmd_rw;
        fifo_din[CMD_ADDR_HI:CMD_ADDR_LO]      = cmd_addr;
        fifo_din[CMD_WDATA_HI:CMD_WDATA_LO]    = cmd_wdata;
    end

    i2c_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;

    // Zero in IDLE guarantees a fresh count on every entry to ISSUE.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || state == RESP) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = ((state == ISSUE) || (state == WAIT)) && (to_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (timeout_hit) begin
            rsp_err <= 1'b1;
        end else if (state == WAIT && ctl_ready) begin
            rsp_err <= 1'b0;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign rsp_err            = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        fifo_pop        = 1'b0;
        ctl_addr_nxt    = ctl_addr;
        ctl_data_in_nxt = ctl_data_in;
        ctl_rw_nxt      = ctl_rw;
        ctl_enable_nxt  = ctl_enable;
        rsp_valid_nxt   = rsp_valid;
        rsp_data_nxt    = rsp_data;

        case (state)
            IDLE: begin
                if (!fifo_empty && ctl_ready) begin
                    fifo_pop        = 1'b1;
                    ctl_rw_nxt      = fifo_dout[CMD_RW];
                    ctl_addr_nxt    = fifo_dout[CMD_ADDR_HI:CMD_ADDR_LO];
                    ctl_data_in_nxt = fifo_dout[CMD_WDATA_HI:CMD_WDATA_LO];
                    ctl_enable_nxt  = 1'b1;
                    state_nxt       = ISSUE;
                end
            end
            ISSUE: begin
                // ctl_ready falling is the controller's acknowledge of the start request.
                if (timeout_hit) begin
                    ctl_enable_nxt = 1'b0;
                    rsp_data_nxt   = '0;
                    rsp_valid_nxt  = 1'b1;
                    state_nxt      = RESP;
                end else if (!ctl_ready) begin
                    ctl_enable_nxt = 1'b0;
                    state_nxt      = WAIT;
                end
            end
            WAIT: begin
                if (timeout_hit) begin
                    rsp_data_nxt  = '0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else if (ctl_ready) begin
                    rsp_data_nxt  = ctl_rw ? ctl_data_out : '0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ctl_addr    <= '0;
            ctl_data_in <= '0;
            ctl_rw      <= 1'b0;
            ctl_enable  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
        end else begin
            state       <= state_nxt;
            ctl_addr    <= ctl_addr_nxt;
            ctl_data_in <= ctl_data_in_nxt;
            ctl_rw      <= ctl_rw_nxt;
            ctl_enable  <= ctl_enable_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_data    <= rsp_data_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: behavioural controller/slave, queue-based model, directed scenarios.
`timescale 1ns/100ps
module tb_i2c_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TOUT  = 16;
    localparam int BUSY_DLY = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic [$clog2(DEPTH):0] level;
    logic [6:0] ctl_addr;
    logic [7:0] ctl_data_in;
    logic       ctl_rw;
    logic       ctl_enable;
    logic [7:0] ctl_data_out;
    logic       ctl_ready;

    always #1 clk = ~clk;

    i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .level(level),
        .ctl_addr(ctl_addr), .ctl_data_in(ctl_data_in), .ctl_rw(ctl_rw), .ctl_enable(ctl_enable),
        .ctl_data_out(ctl_data_out), .ctl_ready(ctl_ready)
    );

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   n_rsp = 0;
    logic hang  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave read contents: 0x2A holds 0x55, every other address returns {1, addr}.
    function automatic logic [7:0] rd_byte(input logic [6:0] a);
        return (a == 7'h2A) ? 8'h55 : {1'b1, a};
    endfunction

    // Behavioural i2c_controller: ready drops one cycle after enable, returns BUSY_DLY cycles later.
    initial begin : ctl_model
        int         c_state;
        int         cnt;
        logic       lrw;
        logic [6:0] la;
        ctl_ready    = 1'b1;
        ctl_data_out = 8'h00;
        c_state = 0;
        cnt = 0;
        lrw = 1'b0;
        la = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                c_state   = 0;
                ctl_ready = 1'b1;
            end else begin
                case (c_state)
                    0: if (ctl_enable) begin
                        lrw = ctl_rw; la = ctl_addr; cnt = 1; c_state = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            ctl_ready = 1'b0; ctl_data_out = 8'hEE;
                            cnt = BUSY_DLY; c_state = hang ? 3 : 2;
                        end
                    end
                    2: begin
                        cnt--;
                        if (cnt == 0) begin
                            ctl_data_out = lrw ? rd_byte(la) : 8'hEE;
                            ctl_ready = 1'b1; c_state = 0;
                        end
                    end
                    default: if (!hang) begin
                        ctl_ready = 1'b1; c_state = 0;
                    end
                endcase
            end
        end
    end

    // Transaction-level model: queued commands, expected responses in order, one outstanding.
    cmd_t       q_cmd[$];
    logic [8:0] q_rsp[$];

    initial begin : monitor
        bit   pend_rst, pend_push, pend_hs, prev_en, prev_rst, outstanding;
        cmd_t pend_cmd;
        cmd_t cur;
        pend_rst = 0; pend_push = 0; pend_hs = 0; prev_en = 0; prev_rst = 0; outstanding = 0;
        pend_cmd = '0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (pend_rst) begin
                q_cmd.delete(); q_rsp.delete(); outstanding = 0;
            end else begin
                if (pend_push) q_cmd.push_back(pend_cmd);
                if (pend_hs) begin
                    if (q_rsp.size() > 0) void'(q_rsp.pop_front());
                    outstanding = 0;
                end
            end

            if (!rst && ctl_enable && !prev_en) begin
                chk("single_outstanding", 32'(outstanding), 0);
                if (q_cmd.size() == 0) begin
                    chk("issue_without_cmd", 1, 0);
                end else begin
                    cur = q_cmd.pop_front();
                    if (hang) q_rsp.push_back({1'b1, 8'h00});
                    else      q_rsp.push_back({1'b0, cur.rw ? rd_byte(cur.addr) : 8'h00});
                    outstanding = 1;
                end
            end

            if (rst && prev_rst) begin
                chk("reset_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
                                      ctl_addr, ctl_data_in, ctl_rw, ctl_enable}, 0);
                chk("reset_level", 32'(level), 0);
            end else if (!rst) begin
                chk("level", 32'(level), q_cmd.size());
                chk("cmd_ready", 32'(cmd_ready), (q_cmd.size() < DEPTH) ? 1 : 0);
                chk("busy", 32'(busy), (q_cmd.size() != 0 || outstanding) ? 1 : 0);
                if (outstanding) chk("ctl_fields_stable", {ctl_rw, ctl_addr, ctl_data_in}, cur);
                if (rsp_valid)   chk("stale_rsp", 32'(outstanding), 1);
            end

            pend_rst  = rst;
            pend_push = !rst && cmd_valid && cmd_ready;
            pend_cmd  = {cmd_rw, cmd_addr, cmd_wdata};
            pend_hs   = !rst && rsp_valid && rsp_ready;
            if (pend_hs) begin
                n_rsp++;
                if (q_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
                else                   chk("rsp_value", {rsp_err, rsp_data}, q_rsp[0]);
            end
            prev_en  = ctl_enable;
            prev_rst = rst;
        end
    end

    task automatic tick();
        @(posedge clk);
        #0.2;
    endtask

    task automatic push_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d);
        int t = 0;
        tick();
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        while (!cmd_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            chk("push_timeout", 0, 1);
            cmd_valid = 1'b0;
            tick();
        end else begin
            tick();
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input string nm, output logic [7:0] d, output logic e);
        int t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) chk({nm, "_rsp_timeout"}, 0, 1);
        d = rsp_data;
        e = rsp_err;
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        @(negedge clk);
        while (busy && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk({nm, "_idle_timeout"}, 0, 1);
    endtask

    task automatic wait_en(input logic val, input string nm);
        int t = 0;
        @(negedge clk);
        while (ctl_enable !== val && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (ctl_enable !== val) chk({nm, "_enable_timeout"}, 0, 1);
    endtask

    initial begin : stim
        logic [7:0] d;
        logic       e;
        int         base;
        int         cnt;
        bit         seen;

        // Reset: 50 cycles, then cmd_ready must rise with an empty FIFO.
        repeat (50) @(posedge clk);
        #0.2 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_ready", 32'(cmd_ready), 1);
        chk("post_reset_level", 32'(level), 0);

        // Single write: enable on the second edge counting the push edge.
        tick();
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h2A; cmd_wdata = 8'hAA;
        @(negedge clk);
        chk("w_cmd_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("w_enable_edge1", 32'(ctl_enable), 0);
        @(negedge clk);
        chk("w_enable_edge2", 32'(ctl_enable), 1);
        chk("w_ctl_addr", 32'(ctl_addr), 32'h2A);
        chk("w_ctl_data_in", 32'(ctl_data_in), 32'hAA);
        chk("w_ctl_rw", 32'(ctl_rw), 0);
        base = n_rsp;
        wait_rsp("w", d, e);
        chk("w_rsp_data", 32'(d), 0);
        chk("w_rsp_err", 32'(e), 0);
        wait_idle("w");
        repeat (10) @(negedge clk);
        chk("w_one_response", n_rsp - base, 1);

        // Read from 0x2A, slave returns 0x55.
        push_cmd(1'b1, 7'h2A, 8'h3C);
        wait_en(1'b1, "r");
        chk("r_ctl_rw_issue", 32'(ctl_rw), 1);
        wait_rsp("r", d, e);
        chk("r_rsp_data", 32'(d), 32'h55);
        chk("r_rsp_err", 32'(e), 0);
        chk("r_ctl_rw_resp", 32'(ctl_rw), 1);
        wait_idle("r");

        // Mixed back-to-back traffic, checked by the model.
        base = n_rsp;
        push_cmd(1'b0, 7'h10, 8'h01);
        push_cmd(1'b1, 7'h33, 8'h00);
        push_cmd(1'b1, 7'h2A, 8'hFF);
        push_cmd(1'b0, 7'h7F, 8'h5A);
        wait_idle("mix");
        chk("mix_responses", n_rsp - base, 4);

        // Backpressure: hold one response, fill the FIFO, stall one more push.
        tick();
        rsp_ready = 1'b0;
        base = n_rsp;
        push_cmd(1'b1, 7'h11, 8'h00);
        wait_rsp("bp0", d, e);
        chk("bp0_rsp_data", 32'(d), 32'h91);
        for (int i = 0; i < DEPTH; i++) push_cmd(i[0], 7'(8'h20 + i), 8'(8'hC0 + i));
        @(negedge clk);
        chk("bp_level_full", 32'(level), DEPTH);
        chk("bp_cmd_ready_low", 32'(cmd_ready), 0);
        fork
            push_cmd(1'b1, 7'h24, 8'h00);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_stall_ready", 32'(cmd_ready), 0);
                    chk("bp_stall_level", 32'(level), DEPTH);
                end
                tick();
                rsp_ready = 1'b1;
            end
        join
        wait_idle("bp");
        chk("bp_responses", n_rsp - base, DEPTH + 2);

        // Reset while a read sits in WAIT with two commands queued.
        base = n_rsp;
        push_cmd(1'b1, 7'h2A, 8'h00);
        wait_en(1'b1, "mr");
        push_cmd(1'b0, 7'h05, 8'h11);
        push_cmd(1'b1, 7'h06, 8'h00);
        wait_en(1'b0, "mr");
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mr_pre_busy", 32'(busy), 1);
        chk("mr_pre_level", 32'(level), 2);
        chk("mr_pre_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("mr_enable", 32'(ctl_enable), 0);
        chk("mr_rsp_valid", 32'(rsp_valid), 0);
        chk("mr_level", 32'(level), 0);
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid || ctl_enable) seen = 1;
        end
        chk("mr_no_stale", 32'(seen), 0);
        chk("mr_responses", n_rsp - base, 0);

`ifdef I2C_SEQ_TIMEOUT_EN
        // Timeout: controller never returns ready; abort arrives TOUT cycles after ISSUE.
        tick();
        hang = 1'b1;
        rsp_ready = 1'b0;
        base = n_rsp;
        push_cmd(1'b0, 7'h40, 8'h99);
        wait_en(1'b1, "to");
        cnt = 0;
        while (!rsp_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("to_latency", cnt, TOUT);
        chk("to_rsp_err", 32'(rsp_err), 1);
        chk("to_rsp_data", 32'(rsp_data), 0);
        chk("to_enable", 32'(ctl_enable), 0);
        push_cmd(1'b1, 7'h2A, 8'h00);
        hang = 1'b0;
        tick();
        rsp_ready = 1'b1;
        wait_rsp("to_next", d, e);
        chk("to_next_rsp_data", 32'(d), 32'h55);
        chk("to_next_rsp_err", 32'(e), 0);
        wait_idle("to");
        chk("to_responses", n_rsp - base, 2);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #150000;
        $display("FAIL watchdog: run did not complete, %0d vectors, %0d miscompares", n_vec, n_bad);
        $fatal(1);
    end

endmodule
